act_fetch_sched: RTL

//  Job-level scheduler that sequences the activation dispatcher (CTRLACT_PlsFetch/CTRLACT_GetAct pair).

---
 rtl/act_sched_pkg.sv | 19 +
 rtl/act_credit_cnt.sv | 27 ++
 rtl/act_fetch_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/act_sched_pkg.sv
// Shared definitions for the activation fetch scheduler: state encoding and default widths.
package act_sched_pkg;

  localparam int BLK_W_DEF = 16;
  localparam int RPT_W_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b11;
  localparam logic [1:0] ST_DONE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    DONE  = ST_DONE
  } sched_state_e;

endpackage

// File: rtl/act_credit_cnt.sv
// Saturating GBF write-credit counter: counts written blocks up to a limit, with a clear
// that can coincide with the first increment.
module act_credit_cnt
  import act_sched_pkg::*;
#(
  parameter int CNT_W = BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      // A write landing in the clearing cycle is the first credit of the new job
      count <= (inc && (limit != '0)) ? CNT_W'(1) : '0;
    end else if (inc && (count < limit)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/act_fetch_sched.sv
// Job-level scheduler for the activation dispatcher: credit-gated fetch pulses per block,
// NumRpt replays for weight reuse, block free on the final pass, progress/done/error reporting.
module act_fetch_sched
  import act_sched_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CFG_Val,
  output logic             CFG_Rdy,
  input  logic [BLK_W-1:0] CFG_NumBlk,
  input  logic [RPT_W-1:0] CFG_NumRpt,
  input  logic             CTRL_Abort,
  input  logic             GBF_BlkWr,
  output logic             GBF_BlkFree,
  output logic             CTRLACT_PlsFetch,
  input  logic             CTRLACT_GetAct,
  output logic [BLK_W-1:0] SCHED_BlkIdx,
  output logic [RPT_W-1:0] SCHED_RptIdx,
  output logic             SCHED_Busy,
  output logic             SCHED_Done,
  output logic             SCHED_Err
);

  sched_state_e     state, state_d;
  logic [BLK_W-1:0] num_blk, num_blk_d, blk_idx, blk_idx_d;
  logic [RPT_W-1:0] num_rpt, num_rpt_d, rpt_idx, rpt_idx_d;
  logic [BLK_W-1:0] wr_cnt, credit_limit;
  logic             fetch_d, free_d, done_d, err_d;
  logic             accept, credit_ok, last_blk, last_rpt;
  logic             credit_clr, credit_inc;

  assign accept     = (state == IDLE) && CFG_Val && !CTRL_Abort;
  assign CFG_Rdy    = (state == IDLE) && !CTRL_Abort;
  assign SCHED_Busy = (state != IDLE);

  assign SCHED_BlkIdx = blk_idx;
  assign SCHED_RptIdx = rpt_idx;

  // The "minus one" forms are only meaningful for a nonzero count
  assign last_blk  = (num_blk != '0) && (blk_idx == num_blk - BLK_W'(1));
  assign last_rpt  = (num_rpt != '0) && (rpt_idx == num_rpt - RPT_W'(1));
  assign credit_ok = (rpt_idx != '0) || (blk_idx < wr_cnt);

  // During accept the job's block count is still on the config bus
  assign credit_clr   = accept || CTRL_Abort;
  assign credit_inc   = GBF_BlkWr && !CTRL_Abort && ((state != IDLE) || accept);
  assign credit_limit = (state == IDLE) ? CFG_NumBlk : num_blk;

  act_credit_cnt #(
    .CNT_W (BLK_W)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (credit_clr),
    .inc   (credit_inc),
    .limit (credit_limit),
    .count (wr_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    num_blk_d = num_blk;
    num_rpt_d = num_rpt;
    blk_idx_d = blk_idx;
    rpt_idx_d = rpt_idx;
    fetch_d   = 1'b0;
    free_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = SCHED_Err;
    if (CTRL_Abort) begin
      state_d   = IDLE;
      blk_idx_d = '0;
      rpt_idx_d = '0;
    end else begin
      if (CTRLACT_GetAct && (state != WAIT)) begin
        err_d = 1'b1;
      end
      case (state)
        IDLE: begin
          if (CFG_Val) begin
            num_blk_d = CFG_NumBlk;
            num_rpt_d = CFG_NumRpt;
            blk_idx_d = '0;
            rpt_idx_d = '0;
            err_d     = CTRLACT_GetAct;
            state_d   = ((CFG_NumBlk == '0) || (CFG_NumRpt == '0)) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            fetch_d = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (CTRLACT_GetAct) begin
            free_d = last_rpt;
            if (last_blk && last_rpt) begin
              state_d = DONE;
            end else if (last_blk) begin
              blk_idx_d = '0;
              rpt_idx_d = rpt_idx + RPT_W'(1);
              state_d   = ISSUE;
            end else begin
              blk_idx_d = blk_idx + BLK_W'(1);
              state_d   = ISSUE;
            end
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_blk          <= '0;
      num_rpt          <= '0;
      blk_idx          <= '0;
      rpt_idx          <= '0;
      CTRLACT_PlsFetch <= 1'b0;
      GBF_BlkFree      <= 1'b0;
      SCHED_Done       <= 1'b0;
      SCHED_Err        <= 1'b0;
    end else begin
      num_blk          <= num_blk_d;
      num_rpt          <= num_rpt_d;
      blk_idx          <= blk_idx_d;
      rpt_idx          <= rpt_idx_d;
      CTRLACT_PlsFetch <= fetch_d;
      GBF_BlkFree      <= free_d;
      SCHED_Done       <= done_d;
      SCHED_Err        <= err_d;
    end
  end

endmodule
